// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT stage sequencer.
//   ntt_state_e : sequencer FSM states
//   NTT_LOG_N   : default log2 of the transform length
//   NTT_N       : default transform length
//   NTT_HALF_N  : default butterflies per stage
//   half_n()    : butterflies per stage for an arbitrary LOG_N
//   ctr_w()     : bit width of the in-flight butterfly counter
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_state_e;

  localparam int unsigned NTT_LOG_N  = 10;
  localparam int unsigned NTT_N      = 1 << NTT_LOG_N;
  localparam int unsigned NTT_HALF_N = NTT_N / 2;

  function automatic int unsigned half_n(input int unsigned log_n);
    return 32'd1 << (log_n - 32'd1);
  endfunction

  // Counter must be able to hold the value max_out itself.
  function automatic int unsigned ctr_w(input int unsigned max_out);
    return $clog2(max_out + 32'd1);
  endfunction

endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Control and butterfly-command bundle between the start/done control,
// the sequencer and the butterfly datapath.
//   master : sequencer side (drives command, status and error)
//   slave  : environment side (drives start, ready, writeback, inverse)
// Optional port inverse exists only when NTT_INVERSE_EN is defined.
interface ntt_stage_sequencer_if
  import ntt_pkg::*;
#(
  parameter int unsigned LOG_N = NTT_LOG_N,
  parameter int unsigned TW_AW = 13
);
  logic             start;
  logic             busy;
  logic             ntt_done;
  logic             bfly_valid;
  logic             bfly_ready;
  logic [LOG_N-1:0] addr_a;
  logic [LOG_N-1:0] addr_b;
  logic [TW_AW-1:0] tw_addr;
  logic             wb_valid;
  logic             err;
`ifdef NTT_INVERSE_EN
  logic             inverse;
`endif

  modport master (
    input  start, bfly_ready, wb_valid,
`ifdef NTT_INVERSE_EN
    input  inverse,
`endif
    output busy, ntt_done, bfly_valid, addr_a, addr_b, tw_addr, err
  );

  modport slave (
    output start, bfly_ready, wb_valid,
`ifdef NTT_INVERSE_EN
    output inverse,
`endif
    input  busy, ntt_done, bfly_valid, addr_a, addr_b, tw_addr, err
  );

endinterface

// File: rtl/ntt_inflight_ctr.sv
// Saturating up/down counter of issued-but-not-written-back butterflies.
//   clk, rst    : clock, synchronous active-high reset
//   inc_i       : butterfly command handshake
//   dec_i       : butterfly writeback pulse
//   zero_o      : registered, count is zero
//   full_nxt_c  : combinational, count after this edge equals MAX_OUT
//   err_o       : sticky, decrement requested at zero
module ntt_inflight_ctr
  import ntt_pkg::*;
#(
  parameter int unsigned MAX_OUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic full_nxt_c,
  output logic err_o
);

  localparam int unsigned CW = ctr_w(MAX_OUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          zero_q;

  // Simultaneous inc and dec cancel; a lone dec at zero is an underflow.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != CW'(MAX_OUT)) cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  assign full_nxt_c = (cnt_d == CW'(MAX_OUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;
  assign err_o  = err_q;

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequences an in-place radix-2 DIT NTT: one butterfly command per
// handshake, draining all writebacks at every stage boundary.
//   clk, rst : clock, synchronous active-high reset
//   ctl      : ntt_stage_sequencer_if.master (start/busy/ntt_done,
//              bfly_valid/bfly_ready, addr_a/addr_b/tw_addr, wb_valid, err)
// Define NTT_INVERSE_EN to add the inverse input; when sampled high at
// start, twiddle addresses are offset into the inverse table.
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int unsigned LOG_N           = NTT_LOG_N,
  parameter int unsigned TW_AW           = 13,
  parameter int unsigned TW_BASE         = 0,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input logic                  clk,
  input logic                  rst,
  ntt_stage_sequencer_if.master ctl
);

  localparam int unsigned HALF_N = (LOG_N == NTT_LOG_N) ? NTT_HALF_N : half_n(LOG_N);
  localparam int unsigned BW     = LOG_N - 1;
  localparam int unsigned SW     = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  ntt_state_e       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [BW-1:0]    b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [LOG_N-1:0] addr_a_q, addr_a_d;
  logic [LOG_N-1:0] addr_b_q, addr_b_d;
  logic [TW_AW-1:0] tw_q, tw_d;
  logic             inv_d;
`ifdef NTT_INVERSE_EN
  logic             inv_q;
`endif

  logic hs;
  logic start_acc;
  logic ctr_zero;
  logic ctr_full_nxt;
  logic ctr_err;

  assign hs        = valid_q && ctl.bfly_ready;
  assign start_acc = (state_q == IDLE) && ctl.start;

  ntt_inflight_ctr #(
    .MAX_OUT (MAX_OUTSTANDING)
  ) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (hs),
    .dec_i      (ctl.wb_valid),
    .zero_o     (ctr_zero),
    .full_nxt_c (ctr_full_nxt),
    .err_o      (ctr_err)
  );

  // Next state, stage/butterfly counters and registered status.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (ctl.start) begin
          state_d = ISSUE;
          s_d     = '0;
          b_d     = '0;
        end
      end
      ISSUE: begin
        if (hs) begin
          if (b_q == BW'(HALF_N - 1)) state_d = DRAIN;
          else                        b_d     = b_q + BW'(1);
        end
      end
      DRAIN: begin
        if (ctr_zero) begin
          if (s_q == SW'(LOG_N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
            b_d     = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Valid only from the second ISSUE cycle on, so addresses lead by one.
    valid_d = (state_q == ISSUE) && (state_d == ISSUE) && !ctr_full_nxt;
    busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
    done_d  = done_q;
    if (start_acc)              done_d = 1'b0;
    else if (state_d == DONE)   done_d = 1'b1;
`ifdef NTT_INVERSE_EN
    inv_d = start_acc ? ctl.inverse : inv_q;
`else
    inv_d = 1'b0;
`endif
  end

  // Butterfly addresses from the next b/s, so they settle with the counters.
  always_comb begin
    logic [LOG_N-1:0] bx;
    logic [LOG_N-1:0] mask;
    logic [LOG_N-1:0] lo;
    logic [SW-1:0]    sh;
    bx       = LOG_N'(b_d);
    mask     = (LOG_N'(1) << s_d) - LOG_N'(1);
    lo       = bx & mask;
    addr_a_d = ((bx & ~mask) << 1) | lo;
    addr_b_d = addr_a_d | (LOG_N'(1) << s_d);
    sh       = SW'(LOG_N - 1) - s_d;
    tw_d     = TW_AW'(TW_BASE) + (TW_AW'(lo) << sh);
    if (inv_d) tw_d = tw_d + TW_AW'(HALF_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
`ifdef NTT_INVERSE_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
`ifdef NTT_INVERSE_EN
      inv_q    <= inv_d;
`endif
    end
  end

  assign ctl.busy       = busy_q;
  assign ctl.ntt_done   = done_q;
  assign ctl.bfly_valid = valid_q;
  assign ctl.addr_a     = addr_a_q;
  assign ctl.addr_b     = addr_b_q;
  assign ctl.tw_addr    = tw_q;
  assign ctl.err        = ctr_err;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer with LOG_N=3: full transforms with
// and without backpressure, stage drain, outstanding limit, reset recovery.
module tb_ntt_stage_sequencer;

  localparam int unsigned LOG_N = 3;
  localparam int unsigned TW_AW = 13;

  logic clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  ntt_stage_sequencer_if #(.LOG_N(LOG_N), .TW_AW(TW_AW)) bus  ();
  ntt_stage_sequencer_if #(.LOG_N(LOG_N), .TW_AW(TW_AW)) bus2 ();

  ntt_stage_sequencer #(
    .LOG_N(LOG_N), .TW_AW(TW_AW), .TW_BASE(0), .MAX_OUTSTANDING(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  ntt_stage_sequencer #(
    .LOG_N(LOG_N), .TW_AW(TW_AW), .TW_BASE(0), .MAX_OUTSTANDING(2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .ctl (bus2)
  );

  always #5 clk = ~clk;

  // Hand-computed command sequence for N=8.
  logic [31:0] exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  logic [31:0] exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  logic [31:0] exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic [31:0] obs_a  [12];
  logic [31:0] obs_b  [12];
  logic [31:0] obs_tw [12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transform on dut; stops early once stop_at commands issued.
  task automatic run_xfer(input bit rnd_ready, input bit poke_start, input int stop_at);
    int          stp, first_v, issued, outst;
    logic [2:0]  pipe;
    bit          stalled, seen_done, hsn, wbn;
    logic [31:0] pa, pb, pt;
    issued = 0; outst = 0; pipe = '0; first_v = 0;
    stalled = 0; seen_done = 0; pa = '0; pb = '0; pt = '0;
    bus.wb_valid = 1'b0; bus.bfly_ready = 1'b1; bus.start = 1'b0;
    step(); step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_clr_on_start", 32'(bus.ntt_done), 32'd0);
    stp = 1;
    while (!seen_done && (issued < stop_at || stop_at >= 12) && stp < 400) begin
      if (bus.bfly_valid && first_v == 0) first_v = stp;
      if (stalled) begin
        chk("stall_valid", 32'(bus.bfly_valid), 32'd1);
        chk("stall_addr_a", 32'(bus.addr_a), pa);
        chk("stall_addr_b", 32'(bus.addr_b), pb);
        chk("stall_tw", 32'(bus.tw_addr), pt);
      end
      bus.bfly_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wbn            = pipe[2];
      bus.wb_valid   = wbn;
      bus.start      = poke_start && (issued == 6);
      hsn            = bus.bfly_valid && bus.bfly_ready;
      if (hsn) begin
        if (issued == 4 || issued == 8)
          chk($sformatf("drain_before_cmd%0d", issued), 32'(outst), 32'd0);
        if (issued < 12) begin
          obs_a[issued]  = 32'(bus.addr_a);
          obs_b[issued]  = 32'(bus.addr_b);
          obs_tw[issued] = 32'(bus.tw_addr);
        end
        issued++;
      end
      stalled = bus.bfly_valid && !bus.bfly_ready;
      pa = 32'(bus.addr_a); pb = 32'(bus.addr_b); pt = 32'(bus.tw_addr);
      outst = outst + int'(hsn) - int'(wbn);
      pipe  = {pipe[1:0], hsn};
      step();
      stp++;
      if (bus.ntt_done) begin
        seen_done = 1;
        chk("done_after_last_wb", 32'(outst), 32'd0);
        chk("done_busy_low", 32'(bus.busy), 32'd0);
      end
    end
    bus.start = 1'b0; bus.wb_valid = 1'b0;
    if (stop_at >= 12) begin
      chk("first_valid_latency", 32'(first_v), 32'd2);
      chk("cmd_count", 32'(issued), 32'd12);
      chk("done_seen", 32'(seen_done), 32'd1);
    end
  endtask

  task automatic check_seq(input string run, input int unsigned tw_off);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s_cmd%0d_a", run, i), obs_a[i], exp_a[i]);
      chk($sformatf("%s_cmd%0d_b", run, i), obs_b[i], exp_b[i]);
      chk($sformatf("%s_cmd%0d_tw", run, i), obs_tw[i], exp_tw[i] + tw_off);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0;  bus.bfly_ready = 1'b1;  bus.wb_valid = 1'b0;
    bus2.start = 1'b0; bus2.bfly_ready = 1'b1; bus2.wb_valid = 1'b0;
`ifdef NTT_INVERSE_EN
    bus.inverse = 1'b0; bus2.inverse = 1'b0;
`endif
    repeat (3) step();

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.ntt_done), 32'd0);
    chk("rst_valid", 32'(bus.bfly_valid), 32'd0);
    chk("rst_addr_a", 32'(bus.addr_a), 32'd0);
    chk("rst_addr_b", 32'(bus.addr_b), 32'd0);
    chk("rst_tw", 32'(bus.tw_addr), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    step();

    // Full transform, no backpressure.
    run_xfer(1'b0, 1'b0, 12);
    check_seq("fwd", 0);
    repeat (3) step();
    chk("done_held", 32'(bus.ntt_done), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Random backpressure plus a start pulse while busy.
    run_xfer(1'b1, 1'b1, 12);
    check_seq("bp", 0);

    // Outstanding limit of 2 with writebacks withheld.
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    n = 0;
    repeat (10) begin
      if (bus2.bfly_valid && bus2.bfly_ready) begin
        chk($sformatf("max_cmd%0d_a", n), 32'(bus2.addr_a), 32'(2 * n));
        chk($sformatf("max_cmd%0d_b", n), 32'(bus2.addr_b), 32'(2 * n + 1));
        n++;
      end
      step();
    end
    chk("max_issues", 32'(n), 32'd2);
    chk("max_valid_low", 32'(bus2.bfly_valid), 32'd0);
    bus2.wb_valid = 1'b1;
    step();
    bus2.wb_valid = 1'b0;
    n = 0;
    repeat (6) begin
      if (bus2.bfly_valid && bus2.bfly_ready) begin
        chk("max_third_a", 32'(bus2.addr_a), 32'd4);
        chk("max_third_b", 32'(bus2.addr_b), 32'd5);
        n++;
      end
      step();
    end
    chk("max_after_wb_issues", 32'(n), 32'd1);

    // Reset in the middle of stage 1, then a stray writeback.
    run_xfer(1'b0, 1'b0, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.ntt_done), 32'd0);
    chk("mid_rst_valid", 32'(bus.bfly_valid), 32'd0);
    chk("mid_rst_addr_a", 32'(bus.addr_a), 32'd0);
    chk("mid_rst_addr_b", 32'(bus.addr_b), 32'd0);
    chk("mid_rst_tw", 32'(bus.tw_addr), 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    bus.wb_valid = 1'b1;
    step();
    bus.wb_valid = 1'b0;
    chk("stray_wb_err", 32'(bus.err), 32'd1);
    chk("stray_wb_valid", 32'(bus.bfly_valid), 32'd0);
    run_xfer(1'b0, 1'b0, 12);
    check_seq("post_rst", 0);
    chk("err_sticky", 32'(bus.err), 32'd1);

`ifdef NTT_INVERSE_EN
    bus.inverse = 1'b1;
    run_xfer(1'b0, 1'b0, 12);
    bus.inverse = 1'b0;
    check_seq("inv", 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
